gate_test_seq: RTL and testbench
================================

# gate_test_seq

Self-checking sequencer for the two-input gate exercise circuits. It replaces the two manual input switches with a clocked driver: it walks the gate's inputs through all four combinations, waits a settle time, samples the gate output, and compares it against the truth table of a selected function. It sits between the board clock/reset and the gate under test, and its pass/fail outputs drive the result LEDs.

## Interface
- `SETTLE`, default 2: cycles each vector is held before sampling; legal range 1..255.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a run; accepted only in IDLE.
- `func`, in, 2: expected function; 00 AND, 01 OR, 10 XOR, 11 NAND. Latched when `start` is accepted.
- `a`, out, 1: drives gate input I0.
- `b`, out, 1: drives gate input I1.
- `z`, in, 1: gate output Z; same clock domain, no synchronizer.
- `busy`, out, 1: high from the cycle after `start` is accepted until DONE is left.
- `done`, out, 1: one-cycle pulse in the DONE state.
- `pass`, out, 1: high when the last run had no mismatches; holds until the next accepted `start`.
- `fail_mask`, out, 4: bit i set when vector i mismatched; holds until the next accepted `start`.

## Operation
- States:
  - IDLE
  - DRIVE: per-vector settle counter.
  - SAMPLE
  - DONE
- Vector index `idx` runs 0..3. `a = idx[0]`, `b = idx[1]`, so the order is (a,b) = 00, 10, 01, 11.
- IDLE with `start`=1 → DRIVE:
  - `idx`=0, counter=0.
  - `func` latched.
  - `fail_mask` and `pass` cleared.
  - `a`/`b` set to 0/0.
- DRIVE: counter increments each cycle. When counter = SETTLE−1, go to SAMPLE.
- SAMPLE:
  - Compare `z` with expected(func_q, a, b).
  - Set `fail_mask[idx]` on mismatch.
  - If `idx`=3, go to DONE. Otherwise increment `idx`, update `a`/`b`, clear the counter, and go to DRIVE.
- DONE:
  - `done`=1.
  - `pass` = (fail_mask == 0), registered.
  - Next state is IDLE, with `a`/`b` returning to 0.
- Expected truth tables over idx 0..3:
  - AND 0001
  - OR 0111
  - XOR 0110
  - NAND 1110
- `start` in DRIVE, SAMPLE or DONE is ignored and not queued.
- `func` changes mid-run are ignored.
- Reset values:
  - `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0000.
  - State is IDLE.
- Reset mid-run aborts immediately. All outputs take their reset values on the next edge and no `done` is issued.

## Timing
- Call the edge where `start` is sampled E0. `a`/`b` for vector 0 are valid after E0.
- Each vector takes SETTLE+1 cycles. `z` for vector i is sampled at edge E0 + (i+1)(SETTLE+1).
- `done` is high for the single cycle after edge E0 + 4(SETTLE+1). With SETTLE=2, that is the cycle after E12.
- `pass` and `fail_mask` are final when `done` is high.
- `start` can be accepted again one cycle after `done`, once back in IDLE.
- SETTLE=1 is legal: DRIVE lasts 1 cycle and SAMPLE lasts 1 cycle.

## Configuration
- `GATE_SEQ_STOP_ON_FAIL_EN` defined:
  - The first mismatch in SAMPLE goes directly to DONE.
  - Later `fail_mask` bits stay 0.
  - `a`/`b` hold the failing vector through DONE and IDLE until the next accepted `start` or reset, so the failing inputs stay visible on the LEDs.
  - A run with no mismatch behaves exactly as in the undefined case.
- Undefined: all four vectors are always applied, and `a`/`b` return to 0 in IDLE.

## Test plan
- Good AND gate, func=00, SETTLE=2, pulse `start`:
  - `a`/`b` follow 00, 10, 01, 11, each held 3 cycles.
  - `done` is high the cycle after E12.
  - `pass`=1, `fail_mask`=0000.
- `z` stuck at 0, func=00 → `fail_mask`=1000, `pass`=0.
- Good AND gate, func=01 (OR), macro undefined → `fail_mask`=0110, `pass`=0, `done` the cycle after E12, `a`/`b`=00 afterwards.
- Same stimulus with `GATE_SEQ_STOP_ON_FAIL_EN` → `done` the cycle after E6, `fail_mask`=0010, `a`=1 and `b`=0 held in IDLE.
- `start` pulsed again during DRIVE of vector 1 → ignored; a single `done` at the expected cycle and unchanged results.
- `rst` asserted at the cycle after E4 → on the next edge all outputs are 0 and the state is IDLE, with no `done`. A subsequent `start` completes a normal run.

Source files
------------

// File: rtl/gate_test_seq.sv
`default_nettype none
// ============================================================================
//  Module      : gate_test_seq
//  Description : Clocked self-checking driver for a two-input gate. Walks
//                (a,b) through 00,10,01,11, samples z after SETTLE+1 cycles
//                per vector and reports pass / per-vector fail_mask.
//                Optional macro GATE_SEQ_STOP_ON_FAIL_EN: stop at the first
//                mismatch and hold the failing vector on a/b.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_test_seq #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] func,
    output logic       a,
    output logic       b,
    input  logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_drive  = 2'd1;
    localparam logic [1:0] c_st_sample = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [7:0] c_cnt_last  = 8'(SETTLE - 1);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic [1:0] r_idx;
    logic [7:0] r_cnt;
    logic [1:0] r_func;
    logic [3:0] r_fail_mask;
    logic       r_pass;

    logic       w_expected;
    logic       w_mismatch;
    logic [3:0] w_fail_upd;
    logic       w_stop;
    logic       w_hold;

    always_comb begin
        w_expected = 1'b0;
        case (r_func)
            2'b00:   w_expected = r_idx[0] & r_idx[1];
            2'b01:   w_expected = r_idx[0] | r_idx[1];
            2'b10:   w_expected = r_idx[0] ^ r_idx[1];
            default: w_expected = ~(r_idx[0] & r_idx[1]);
        endcase
    end

    assign w_mismatch = (z != w_expected);
    assign w_fail_upd = r_fail_mask | ((4'b0001 << r_idx) & {4{w_mismatch}});

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    // A recorded failure keeps the failing vector on a/b after the run.
    assign w_stop = w_mismatch;
    assign w_hold = |r_fail_mask;
`else
    assign w_stop = 1'b0;
    assign w_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:   if (start) w_next_state = c_st_drive;
            c_st_drive:  if (r_cnt == c_cnt_last) w_next_state = c_st_sample;
            c_st_sample: w_next_state = ((r_idx == 2'd3) || w_stop) ? c_st_done : c_st_drive;
            default:     w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= 2'd0;
            r_cnt       <= 8'd0;
            r_func      <= 2'b00;
            r_fail_mask <= 4'b0000;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_idx       <= 2'd0;
                        r_cnt       <= 8'd0;
                        r_func      <= func;
                        r_fail_mask <= 4'b0000;
                        r_pass      <= 1'b0;
                    end
                end
                c_st_drive: begin
                    r_cnt <= r_cnt + 8'd1;
                end
                c_st_sample: begin
                    r_fail_mask <= w_fail_upd;
                    // pass is registered on entry to DONE so it is final while done is high
                    if (w_next_state == c_st_done) begin
                        r_pass <= (w_fail_upd == 4'b0000);
                    end else begin
                        r_idx <= r_idx + 2'd1;
                        r_cnt <= 8'd0;
                    end
                end
                default: begin
                    if (!w_hold) r_idx <= 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        a         = r_idx[0];
        b         = r_idx[1];
        busy      = (r_state != c_st_idle);
        done      = (r_state == c_st_done);
        pass      = r_pass;
        fail_mask = r_fail_mask;
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_test_seq.sv
`default_nettype none
// Bench for gate_test_seq: a modelled gate drives z; table of runs checked through a result queue,
// plus hand sequences for vector timing, ignored start and mid-run reset.
module tb_gate_test_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] func;
    logic       a;
    logic       b;
    logic       z;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    int         gate_kind;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0] func;
        int         gate;
        logic [3:0] mask_full;
    } vec_t;

    typedef struct {
        logic [3:0] mask;
        logic       pass;
        int         lat;
        logic [1:0] ab_after;
    } exp_t;

    exp_t sb_q[$];

    gate_test_seq #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .func(func),
        .a(a), .b(b), .z(z), .busy(busy), .done(done),
        .pass(pass), .fail_mask(fail_mask)
    );

    always #5 clk = ~clk;

    // Gate kinds: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 stuck-0, 5 stuck-1
    function automatic logic gate_fn(input int g, input logic x, input logic y);
        case (g)
            0:       return x & y;
            1:       return x | y;
            2:       return x ^ y;
            3:       return ~(x & y);
            4:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign z = gate_fn(gate_kind, a, b);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic do_start(input logic [1:0] f, input int g);
        @(negedge clk);
        func      = f;
        gate_kind = g;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        func  = ~f;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    function automatic exp_t model(input logic [3:0] mask_full);
        exp_t e;
        e.mask     = mask_full;
        e.lat      = 12;
        e.ab_after = 2'b00;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
        for (int i = 3; i >= 0; i--) begin
            if (mask_full[i]) begin
                e.mask     = 4'b0001 << i;
                e.lat      = 3 * (i + 1);
                e.ab_after = {i[0], i[1]};
            end
        end
`endif
        e.pass = (e.mask == 4'b0000);
        return e;
    endfunction

    vec_t vecs[10];

    initial begin
        int   lat;
        int   dones;
        int   first;
        exp_t e;
        exp_t got;

        vecs[0] = '{2'b00, 0, 4'b0000};
        vecs[1] = '{2'b00, 4, 4'b1000};
        vecs[2] = '{2'b01, 0, 4'b0110};
        vecs[3] = '{2'b10, 2, 4'b0000};
        vecs[4] = '{2'b11, 3, 4'b0000};
        vecs[5] = '{2'b01, 1, 4'b0000};
        vecs[6] = '{2'b11, 5, 4'b1000};
        vecs[7] = '{2'b11, 0, 4'b1111};
        vecs[8] = '{2'b01, 2, 4'b1000};
        vecs[9] = '{2'b00, 5, 4'b0111};

        rst = 1'b1; start = 1'b0; func = 2'b00; gate_kind = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {28'd0, a, b, busy, done}, 32'd0);
        check("reset_pass_mask", {27'd0, pass, fail_mask}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Good AND gate: each vector held three cycles, done after E12
        do_start(2'b00, 0);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("ab_k%0d", k), {30'd0, a, b}, {30'd0, 1'((k / 3) & 1), 1'((k / 3) >> 1)});
            check($sformatf("no_early_done_k%0d", k), {31'd0, done}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("done_at_e12", {31'd0, done}, 32'd1);
        check("and_pass", {31'd0, pass}, 32'd1);
        check("and_mask", {28'd0, fail_mask}, 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_not_busy", {31'd0, busy}, 32'd0);
        check("idle_ab", {30'd0, a, b}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            sb_q.push_back(model(vecs[i].mask_full));
            do_start(vecs[i].func, vecs[i].gate);
            wait_done(lat);
            got = sb_q.pop_front();
            check($sformatf("v%0d_latency", i), lat, got.lat);
            check($sformatf("v%0d_mask", i), {28'd0, fail_mask}, {28'd0, got.mask});
            check($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, got.pass});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ab_after", i), {30'd0, a, b}, {30'd0, got.ab_after});
            check($sformatf("v%0d_busy_after", i), {31'd0, busy}, 32'd0);
        end

        // start re-pulsed during DRIVE of vector 1 must be ignored
        do_start(2'b00, 0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        first = -1;
        for (int k = 5; k <= 24; k++) begin
            if (done) begin
                dones++;
                if (first < 0) first = k;
            end
            @(posedge clk);
            #1;
        end
        check("restart_single_done", dones, 1);
        check("restart_done_cycle", first, 12);
        check("restart_pass", {27'd0, pass, fail_mask}, 32'h10);

        // Reset in the cycle after E4 aborts the run
        do_start(2'b01, 0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_outputs", {28'd0, a, b, busy, done}, 32'd0);
        check("abort_pass_mask", {27'd0, pass, fail_mask}, 32'd0);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            if (done) dones++;
            @(posedge clk);
            #1;
        end
        check("abort_no_done", dones, 0);
        e = model(4'b0000);
        sb_q.push_back(e);
        do_start(2'b10, 2);
        wait_done(lat);
        got = sb_q.pop_front();
        check("post_abort_latency", lat, got.lat);
        check("post_abort_result", {27'd0, pass, fail_mask}, {27'd0, got.pass, got.mask});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
